// File: rtl/user_obi_dma.sv
// user_obi_dma: register-programmed OBI word-copy engine (LEN words SRC -> DST, one transaction outstanding)
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   obi_req_i/rsp  - OBI subordinate register port (SRC, DST, LEN, CTRL, STATUS)
//   mgr_obi_req_o  - OBI manager request towards the crossbar
//   mgr_obi_rsp_i  - OBI manager response from the crossbar
//   irq_o          - level completion interrupt (done & irq_en)
package user_obi_dma_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        aid;
    } obi_a_chan_t;
    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;
    typedef struct packed {
        logic [31:0] rdata;
        logic        rid;
        logic        err;
    } obi_r_chan_t;
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module user_obi_dma import user_obi_dma_pkg::*; #(
    parameter type         sbr_obi_req_t = obi_req_t,
    parameter type         sbr_obi_rsp_t = obi_rsp_t,
    parameter type         mgr_obi_req_t = obi_req_t,
    parameter type         mgr_obi_rsp_t = obi_rsp_t,
    parameter int unsigned LenWidth      = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  sbr_obi_req_t obi_req_i,
    output sbr_obi_rsp_t obi_rsp_o,
    output mgr_obi_req_t mgr_obi_req_o,
    input  mgr_obi_rsp_t mgr_obi_rsp_i,
    output logic         irq_o
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;
    state_e state_q, state_d;
    logic [31:0] src_q, dst_q, cur_src_q, cur_dst_q, data_q;
    logic [LenWidth-1:0] len_q, rem_q;
    logic irq_en_q, done_q, err_q, irq_q, mgr_req_q;
    logic rsp_valid_q, rsp_rid_q, rsp_err_q;
    logic [31:0] rsp_rdata_q, rdata_d;
    logic acc, wr, busy, start, launch, zero_done, hw_done, hw_err, step;
    logic done_d, err_d, irq_en_d, w1c;
    logic [2:0] idx;
    logic [31:0] wdata;
    assign acc       = obi_req_i.req;
    assign wr        = acc & obi_req_i.a.we;
    assign idx       = obi_req_i.a.addr[4:2];
    assign wdata     = obi_req_i.a.wdata;
    assign busy      = state_q != IDLE;
    assign start     = wr && idx == 3'd3 && wdata[0];
    assign launch    = start && !busy && len_q != '0;
    assign zero_done = start && !busy && len_q == '0;
    assign w1c       = wr && idx == 3'd4;
    assign step      = state_q == WR_WAIT && mgr_obi_rsp_i.rvalid && !mgr_obi_rsp_i.r.err;
    always_comb begin
        state_d = state_q;
        hw_done = 1'b0;
        hw_err  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = launch ? RD_REQ : IDLE;
                hw_done = zero_done;
            end
            RD_REQ: state_d = mgr_obi_rsp_i.gnt ? RD_WAIT : RD_REQ;
            RD_WAIT: if (mgr_obi_rsp_i.rvalid) begin
                state_d = mgr_obi_rsp_i.r.err ? IDLE : WR_REQ;
                hw_done = mgr_obi_rsp_i.r.err;
                hw_err  = mgr_obi_rsp_i.r.err;
            end
            WR_REQ: state_d = mgr_obi_rsp_i.gnt ? WR_WAIT : WR_REQ;
            WR_WAIT: if (mgr_obi_rsp_i.rvalid) begin
                hw_err  = mgr_obi_rsp_i.r.err;
                hw_done = mgr_obi_rsp_i.r.err || rem_q == LenWidth'(1);
                state_d = hw_done ? IDLE : RD_REQ;
            end
            default: state_d = IDLE;
        endcase
    end
    // A hardware set beats a same-cycle W1C; a new launch clears stale flags.
    assign done_d   = hw_done ? 1'b1 : (launch || (w1c && wdata[1])) ? 1'b0 : done_q;
    assign err_d    = hw_err ? 1'b1 : (launch || (w1c && wdata[2])) ? 1'b0 : err_q;
    assign irq_en_d = (wr && idx == 3'd3) ? wdata[1] : irq_en_q;
    always_comb begin
        rdata_d = '0;
        case (idx)
            3'd0: rdata_d = src_q;
            3'd1: rdata_d = dst_q;
            3'd2: rdata_d = 32'(len_q);
            3'd3: rdata_d = {30'b0, irq_en_q, 1'b0};
            3'd4: rdata_d = {29'b0, err_q, done_q, busy};
            default: rdata_d = '0;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mgr_req_q   <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            irq_q       <= 1'b0;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rid_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mgr_req_q   <= state_d == RD_REQ || state_d == WR_REQ;
            rsp_valid_q <= acc;
            rsp_rid_q   <= acc & obi_req_i.a.aid;
            rsp_err_q   <= acc && idx > 3'd4;
            rsp_rdata_q <= acc ? rdata_d : '0;
            if (wr && !busy && idx == 3'd0) src_q <= {wdata[31:2], 2'b00};
            if (wr && !busy && idx == 3'd1) dst_q <= {wdata[31:2], 2'b00};
            if (wr && !busy && idx == 3'd2) len_q <= wdata[LenWidth-1:0];
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_q    <= done_d & irq_en_d;
            if (launch) begin
                cur_src_q <= src_q;
                cur_dst_q <= dst_q;
                rem_q     <= len_q;
            end
            if (state_q == RD_WAIT && mgr_obi_rsp_i.rvalid) data_q <= mgr_obi_rsp_i.r.rdata;
            if (step) begin
                cur_src_q <= cur_src_q + 32'd4;
                cur_dst_q <= cur_dst_q + 32'd4;
                rem_q     <= rem_q - LenWidth'(1);
            end
        end
    end
    // Request fields derive from flops only, so they stay stable until gnt.
    always_comb begin
        mgr_obi_req_o         = '0;
        mgr_obi_req_o.req     = mgr_req_q;
        mgr_obi_req_o.a.we    = state_q == WR_REQ;
        mgr_obi_req_o.a.addr  = state_q == WR_REQ ? cur_dst_q : cur_src_q;
        mgr_obi_req_o.a.be    = 4'hF;
        mgr_obi_req_o.a.wdata = data_q;
        mgr_obi_req_o.a.aid   = 1'b0;
    end
    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = obi_req_i.req;
        obi_rsp_o.rvalid  = rsp_valid_q;
        obi_rsp_o.r.rdata = rsp_rdata_q;
        obi_rsp_o.r.rid   = rsp_rid_q;
        obi_rsp_o.r.err   = rsp_err_q;
    end
    assign irq_o = irq_q;
    logic unused_bits;
    assign unused_bits = ^{obi_req_i.a.addr[31:5], obi_req_i.a.addr[1:0], obi_req_i.a.be, mgr_obi_rsp_i.r.rid};
endmodule

// File: tb/tb_user_obi_dma.sv
// tb_user_obi_dma: self-checking bench for user_obi_dma with a memory-backed OBI subordinate model
module tb_user_obi_dma;
    import user_obi_dma_pkg::*;
    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    obi_req_t reg_req = '0;
    obi_rsp_t reg_rsp;
    obi_req_t mreq;
    obi_rsp_t mrsp = '0;
    logic     irq;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    user_obi_dma dut (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(reg_req), .obi_rsp_o(reg_rsp),
        .mgr_obi_req_o(mreq), .mgr_obi_rsp_i(mrsp), .irq_o(irq)
    );
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;
    typedef struct {
        logic        we;
        logic [7:0]  off;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    txn_t log_q[$];
    int stall_max = 0;
    bit req_seen = 0;
    bit pend = 0;
    bit hold = 0;
    int dly = 0;
    int gwait = 0;
    logic [31:0] prd = '0;
    logic perr = 1'b0;
    obi_a_chan_t held = '0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    function automatic bit mapped(input logic [31:0] a);
        return (a & 32'hFFFF_FC00) == 32'h1000_0000;
    endfunction
    // Subordinate model: 256 words at 0x1000_0000, everything else answers err.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mrsp.gnt = 1'b0;
            mrsp.rvalid = 1'b0;
            mrsp.r = '0;
            if (!rst_n) begin
                pend = 0;
                hold = 0;
                gwait = 0;
                continue;
            end
            if (pend) begin
                if (dly == 0) begin
                    mrsp.rvalid = 1'b1;
                    mrsp.r.rdata = prd;
                    mrsp.r.err = perr;
                    pend = 0;
                end else dly--;
            end
            if (mreq.req) begin
                req_seen = 1;
                if (hold) begin
                    chk("a_addr_stable", mreq.a.addr, held.addr);
                    chk("a_we_stable", {31'b0, mreq.a.we}, {31'b0, held.we});
                    chk("a_wdata_stable", mreq.a.wdata, held.wdata);
                end
                if (!pend && !mrsp.rvalid && gwait == 0) begin
                    mrsp.gnt = 1'b1;
                    log_q.push_back('{mreq.a.we, mreq.a.addr, mreq.a.wdata});
                    perr = !mapped(mreq.a.addr);
                    prd = '0;
                    if (!perr && mreq.a.we) mem[mreq.a.addr[9:2]] = mreq.a.wdata;
                    if (!perr && !mreq.a.we) prd = mem[mreq.a.addr[9:2]];
                    pend = 1;
                    dly = stall_max > 0 ? $urandom_range(stall_max - 1, 0) : 0;
                    gwait = stall_max > 0 ? $urandom_range(stall_max, 0) : 0;
                    hold = 0;
                end else begin
                    hold = 1;
                    held = mreq.a;
                    if (gwait > 0) gwait--;
                end
            end
        end
    end
    task automatic reg_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err);
        @(negedge clk);
        reg_req.req = 1'b1;
        reg_req.a.we = we;
        reg_req.a.addr = addr;
        reg_req.a.be = 4'hF;
        reg_req.a.wdata = wdata;
        reg_req.a.aid = 1'b1;
        #1 chk("reg_gnt", {31'b0, reg_rsp.gnt}, 32'd1);
        @(posedge clk);
        #1;
        chk("reg_rvalid_rid", {30'b0, reg_rsp.rvalid, reg_rsp.r.rid}, 32'd3);
        rdata = reg_rsp.r.rdata;
        err = reg_rsp.r.err;
        reg_req = '0;
    endtask
    task automatic wait_idle(output logic [31:0] st);
        logic e;
        st = 32'd1;
        for (int i = 0; i < 3000 && st[0]; i++) reg_acc(1'b0, 32'h10, 32'h0, st, e);
        chk("idle_timeout", {31'b0, st[0]}, 32'd0);
    endtask
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len, input int stall);
        txn_t exp_q[$];
        logic [31:0] st, rd, sa, da, v;
        logic e;
        bit bad;
        int nbad;
        bad = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < len; i++) begin
            sa = src + 32'(4 * i);
            da = dst + 32'(4 * i);
            exp_q.push_back('{1'b0, sa, 32'h0});
            if (!mapped(sa)) begin
                bad = 1;
                break;
            end
            v = ref_mem[sa[9:2]];
            exp_q.push_back('{1'b1, da, v});
            if (!mapped(da)) begin
                bad = 1;
                break;
            end
            ref_mem[da[9:2]] = v;
        end
        stall_max = stall;
        log_q.delete();
        reg_acc(1'b1, 32'h10, 32'h6, rd, e);
        reg_acc(1'b1, 32'h00, src, rd, e);
        reg_acc(1'b1, 32'h04, dst, rd, e);
        reg_acc(1'b1, 32'h08, 32'(len), rd, e);
        reg_acc(1'b1, 32'h0C, 32'h3, rd, e);
        wait_idle(st);
        chk("copy_status", st, bad ? 32'h6 : 32'h2);
        chk("copy_irq", {31'b0, irq}, 32'd1);
        chk("txn_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk($sformatf("txn%0d_we", i), {31'b0, log_q[i].we}, {31'b0, exp_q[i].we});
            chk($sformatf("txn%0d_addr", i), log_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) chk($sformatf("txn%0d_wdata", i), log_q[i].wdata, exp_q[i].wdata);
        end
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("mem_image_diffs", 32'(nbad), 32'd0);
    endtask
    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        vec_t vt[$];
        logic [31:0] rd, st, s, d;
        logic [31:0] init_mem [256];
        logic [31:0] nostall_mem [256];
        logic e;
        int len, nbad;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_irq", {31'b0, irq}, 32'd0);
        chk("reset_mgr_req", {31'b0, mreq.req}, 32'd0);
        chk("reset_rsp_flags", {29'b0, reg_rsp.rvalid, reg_rsp.r.err, reg_rsp.r.rid}, 32'd0);
        chk("reset_rsp_rdata", reg_rsp.r.rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        vt.push_back('{1'b0, 8'h00, 32'h0, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h04, 32'h0, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h08, 32'h0, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h0C, 32'h0, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h10, 32'h0, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h14, 32'h0, 32'h0, 1'b1});
        vt.push_back('{1'b0, 8'h1C, 32'h0, 32'h0, 1'b1});
        vt.push_back('{1'b1, 8'h00, 32'h1234_5677, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h00, 32'h0, 32'h1234_5674, 1'b0});
        vt.push_back('{1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h04, 32'h0, 32'hFFFF_FFFC, 1'b0});
        vt.push_back('{1'b1, 8'h08, 32'h000A_BCDE, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h08, 32'h0, 32'h0000_BCDE, 1'b0});
        vt.push_back('{1'b1, 8'h0C, 32'h2, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h0C, 32'h0, 32'h2, 1'b0});
        vt.push_back('{1'b1, 8'h0C, 32'h0, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h0C, 32'h0, 32'h0, 1'b0});
        vt.push_back('{1'b1, 8'h18, 32'hFFFF_FFFF, 32'h0, 1'b1});
        vt.push_back('{1'b1, 8'h10, 32'h6, 32'h0, 1'b0});
        vt.push_back('{1'b0, 8'h10, 32'h0, 32'h0, 1'b0});
        for (int i = 0; i < vt.size(); i++) begin
            reg_acc(vt[i].we, {24'h0, vt[i].off}, vt[i].wdata, rd, e);
            chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vt[i].err});
            if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
        end
        chk("no_req_after_regs", {31'b0, req_seen}, 32'd0);
        for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);
        run_copy(32'h1000_0000, 32'h1000_0100, 4, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("dst_word%0d", i), mem[64 + i], 32'hA0 + 32'(i));
        reg_acc(1'b1, 32'h10, 32'h6, rd, e);
        reg_acc(1'b0, 32'h10, 32'h0, rd, e);
        chk("status_cleared", rd, 32'h0);
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        req_seen = 0;
        reg_acc(1'b1, 32'h08, 32'h0, rd, e);
        reg_acc(1'b1, 32'h0C, 32'h1, rd, e);
        reg_acc(1'b0, 32'h10, 32'h0, rd, e);
        chk("len0_status", rd, 32'h2);
        repeat (10) @(posedge clk);
        #1;
        chk("len0_no_req", {31'b0, req_seen}, 32'd0);
        chk("len0_irq_disabled", {31'b0, irq}, 32'd0);
        run_copy(32'h2000_0000, 32'h1000_0000, 3, 0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 256; i++) init_mem[i] = $urandom;
            s = 32'h1000_0000 + 32'($urandom_range(243, 0) * 4);
            d = 32'h1000_0000 + 32'($urandom_range(243, 0) * 4);
            len = $urandom_range(12, 1);
            for (int i = 0; i < 256; i++) mem[i] = init_mem[i];
            run_copy(s, d, len, 0);
            for (int i = 0; i < 256; i++) nostall_mem[i] = mem[i];
            for (int i = 0; i < 256; i++) mem[i] = init_mem[i];
            run_copy(s, d, len, 5);
            nbad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== nostall_mem[i]) nbad++;
            chk($sformatf("stall_equiv%0d", k), 32'(nbad), 32'd0);
        end
        for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 + 32'(i);
        stall_max = 5;
        log_q.delete();
        reg_acc(1'b1, 32'h10, 32'h6, rd, e);
        reg_acc(1'b1, 32'h00, 32'h1000_0000, rd, e);
        reg_acc(1'b1, 32'h04, 32'h1000_0200, rd, e);
        reg_acc(1'b1, 32'h08, 32'd4, rd, e);
        reg_acc(1'b1, 32'h0C, 32'h3, rd, e);
        reg_acc(1'b0, 32'h10, 32'h0, rd, e);
        chk("busy_status", rd, 32'h1);
        reg_acc(1'b1, 32'h08, 32'd99, rd, e);
        chk("busy_len_write_err", {31'b0, e}, 32'd0);
        reg_acc(1'b1, 32'h0C, 32'h3, rd, e);
        reg_acc(1'b0, 32'h14, 32'h0, rd, e);
        chk("off14_err", {31'b0, e}, 32'd1);
        wait_idle(st);
        chk("busy_run_status", st, 32'h2);
        reg_acc(1'b0, 32'h08, 32'h0, rd, e);
        chk("len_unchanged", rd, 32'd4);
        chk("no_restart_txns", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 4; i++) chk($sformatf("busy_dst%0d", i), mem[128 + i], 32'hC000_0000 + 32'(i));
        chk("irq_before_w1c", {31'b0, irq}, 32'd1);
        reg_acc(1'b1, 32'h10, 32'h2, rd, e);
        @(posedge clk);
        #1;
        chk("irq_after_w1c", {31'b0, irq}, 32'd0);
        reg_acc(1'b1, 32'h08, 32'd8, rd, e);
        reg_acc(1'b1, 32'h0C, 32'h3, rd, e);
        for (int i = 0; i < 50 && !mreq.req; i++) begin
            @(posedge clk);
            #1;
        end
        chk("req_before_reset", {31'b0, mreq.req}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("req_async_drop", {31'b0, mreq.req}, 32'd0);
        chk("irq_async_drop", {31'b0, irq}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        reg_acc(1'b0, 32'h00, 32'h0, rd, e);
        chk("src_after_reset", rd, 32'h0);
        reg_acc(1'b0, 32'h10, 32'h0, rd, e);
        chk("status_after_reset", rd, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/user_obi_dma.md
Name: user_obi_dma

Overview:
- Register-programmed word-copy engine in the user domain: the OBI *manager* counterpart to the user subordinate bus.
- Configured via an OBI subordinate port, which hangs on the user demux as an additional subordinate.
- Drives the user manager port (currently tied to '0) to copy LEN 32-bit words from SRC to DST through the Croc crossbar.
- One transaction outstanding at a time; level interrupt on completion.

Parameters:
SbrObiCfg, croc_pkg SbrObiCfg, OBI config of the register port
sbr_obi_req_t, sbr_obi_req_t, register port request struct
sbr_obi_rsp_t, sbr_obi_rsp_t, register port response struct
MgrObiCfg, croc_pkg MgrObiCfg, OBI config of the manager port
mgr_obi_req_t, mgr_obi_req_t, manager port request struct
mgr_obi_rsp_t, mgr_obi_rsp_t, manager port response struct
LenWidth, 16, width of the word-count register

Ports:
clk_i  input  1  system clock, single clock domain
rst_ni  input  1  asynchronous active-low reset
obi_req_i  input  sbr_obi_req_t  register port request
obi_rsp_o  output  sbr_obi_rsp_t  register port response
mgr_obi_req_o  output  mgr_obi_req_t  manager port request to crossbar
mgr_obi_rsp_i  input  mgr_obi_rsp_t  manager port response from crossbar
irq_o  output  1  completion interrupt, level, to interrupts_o

Behaviour:
Interface:
- One clock, clk_i.
- Reset rst_ni is asynchronous and active-low.
- All flops are cleared on reset.

Register port:
- gnt = req, combinational.
- rvalid is driven one cycle after a granted req, with rid echoed.
- Address decode uses addr[4:2] (offsets from the block base):
  - 0x00 SRC: RW, 32 bit, bits[1:0] read 0.
  - 0x04 DST: RW, 32 bit, bits[1:0] read 0.
  - 0x08 LEN: RW, LenWidth bits, word count.
  - 0x0C CTRL: W bit0 = start (self-clearing, reads 0); RW bit1 = irq_en.
  - 0x10 STATUS: RO bit0 busy; bit1 done, W1C; bit2 err, W1C.
- Other offsets: rdata 0, err=1, no side effects.
- Writes to SRC, DST or LEN while busy are ignored; the response is still err=0.
- Reset values: all registers 0; obi_rsp_o all 0; irq_o 0.

Manager FSM (states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT):
- IDLE:
  - start with busy=0 and LEN!=0: copy SRC/DST/LEN into working counters, clear done/err, set busy, go to RD_REQ.
  - start with LEN=0: set done, stay IDLE, no bus traffic.
- RD_REQ:
  - Drive a.req=1, we=0, be=4'hF, addr=cur_src.
  - Hold all request fields stable until gnt; on gnt go to RD_WAIT.
- RD_WAIT:
  - On rvalid, latch rdata.
  - If err: set err and done, clear busy, go to IDLE.
  - Otherwise go to WR_REQ.
- WR_REQ:
  - Drive a.req=1, we=1, be=4'hF, addr=cur_dst, wdata=latched data.
  - Hold stable until gnt; on gnt go to WR_WAIT.
- WR_WAIT:
  - On rvalid with err: set err and done, go to IDLE.
  - Otherwise: cur_src+=4, cur_dst+=4 (mod 2^32, wrap allowed), remaining-=1.
  - If remaining becomes 0: set done, clear busy, go to IDLE. Otherwise go to RD_REQ.

Manager request rules:
- a.req is registered, so it asserts the cycle after entering a REQ state.
- Minimum per word: RD req 1 cycle, RD rsp ≥1 cycle, WR req 1 cycle, WR rsp ≥1 cycle.
- aid constant 0.
- rready (if present in config) tied to 1.

Edge cases:
- start while busy: ignored.
- irq_o = done & irq_en, registered. Clearing done via W1C deasserts irq_o the next cycle.
- A register read of STATUS in the same cycle as done-set returns the pre-update value.
- W1C of done in the same cycle as a hardware set: the set wins.
- Reset mid-transfer: a.req drops asynchronously. The outstanding transaction is abandoned; the system reset covers the crossbar.

Test Plan:
- Reset, then read all registers → SRC/DST/LEN/STATUS = 0, irq_o=0, mgr a.req=0.
- Program SRC=0x1000_0000 (SRAM), DST=0x1000_0100, LEN=4, irq_en=1, start; memory preloaded with 0xA0..A3 → DST words match, STATUS=0x2, irq_o=1; exactly 8 manager transactions.
- Start with LEN=0 → STATUS=0x2 the next cycle, no a.req ever asserted.
- Random gnt/rvalid stall injection, up to 5 cycles → addr/we/wdata stable while req && !gnt; result identical to the no-stall run.
- SRC pointing to an unmapped address (err response) → STATUS=0x6 (done+err), busy=0, no write issued.
- During a busy transfer: write LEN=99 and start again, then access offset 0x14 → LEN unchanged and no restart; offset 0x14 returns err=1; W1C to STATUS after completion clears irq_o within 1 cycle.
